// File: rtl/ntt_frame_sequencer.sv
// ntt_frame_sequencer
//   Frame-level controller for the NTT core, sitting between the UART word
//   assembler (inbound words) and the UART byte transmitter (outbound bytes).
//   Sequences three jobs from a single inbound word stream:
//     1. twiddle capture (RADIX/2 words) and decimated preload of the
//        per-stage twiddle RAMs (stage s receives every 2^s-th twiddle);
//     2. input-frame capture (RADIX words) and back-to-back feed to the NTT;
//     3. result capture (RADIX words) and little-endian byte serialisation.
//   Twiddles persist across frames; tw_reload (only at the start of a data
//   frame) returns to twiddle capture.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_data      inbound word stream, accepted when in_ready is high
//   in_ready              high in the two capture states (combinational)
//   tw_reload             request to recapture twiddles
//   ram_we/addr/wdata     per-stage twiddle RAM write port, stage-sliced
//   ntt_start/ntt_data    NTT input, ntt_start high for all RADIX samples
//   res_valid/res_data    NTT result stream
//   tx_start/tx_byte      one-cycle launch of a byte to the transmitter
//   tx_done               transmitter finished the current byte
//   busy                  high whenever not waiting for a data frame
//   frame_done            one-cycle pulse after the last byte is sent
module ntt_frame_sequencer #(
  parameter int W          = 32,
  parameter int RADIX      = 16,
  parameter int NUM_STAGES = $clog2(RADIX),
  parameter int ADDR_WIDTH = $clog2(RADIX/2)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [W-1:0]                     in_data,
  output logic                             in_ready,
  input  logic                             tw_reload,
  output logic [NUM_STAGES-1:0]            ram_we,
  output logic [NUM_STAGES*ADDR_WIDTH-1:0] ram_addr,
  output logic [NUM_STAGES*W-1:0]          ram_wdata,
  output logic                             ntt_start,
  output logic [W-1:0]                     ntt_data,
  input  logic                             res_valid,
  input  logic [W-1:0]                     res_data,
  output logic                             tx_start,
  output logic [7:0]                       tx_byte,
  input  logic                             tx_done,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int IW   = $clog2(RADIX);
  localparam int CW   = IW + 1;
  localparam int HALF = RADIX / 2;
  localparam int BPW  = W / 8;
  localparam int BCW  = $clog2(BPW + 1);
  localparam int SW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    S_TW_RX,
    S_TW_LOAD,
    S_DATA_RX,
    S_FEED,
    S_COLLECT,
    S_SEND_PREP,
    S_SEND_WAIT
  } state_t;

  state_t state_q, state_d;

  // Shared word index: twiddle/data capture, RAM address j, feed, collect,
  // send word. Every state exit clears it, so it never wraps.
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  stg_q, stg_d;
  logic [BCW-1:0] byte_q, byte_d;

  logic [NUM_STAGES-1:0]            ram_we_q, ram_we_d;
  logic [NUM_STAGES*ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [NUM_STAGES*W-1:0]          ram_wdata_q, ram_wdata_d;
  logic                             ntt_start_q, ntt_start_d;
  logic [W-1:0]                     ntt_data_q, ntt_data_d;
  logic                             tx_start_q, tx_start_d;
  logic [7:0]                       tx_byte_q, tx_byte_d;
  logic                             frame_done_q, frame_done_d;

  logic [W-1:0] tw_buf_q [HALF];
  logic [W-1:0] d_buf_q  [RADIX];

  logic                  tw_we;
  logic [ADDR_WIDTH-1:0] tw_waddr;
  logic                  d_we;
  logic [IW-1:0]         d_waddr;
  logic [W-1:0]          d_wdata;

  logic                  wr_go;
  logic [SW-1:0]         wr_stg;
  logic [ADDR_WIDTH-1:0] wr_j;
  logic [ADDR_WIDTH-1:0] tw_idx;
  logic [W-1:0]          sel_word;

  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic [SW-1:0] stg_inc;
  logic [CW-1:0] tw_last;
  logic          cnt_last_half;
  logic          cnt_last_full;

  assign in_ready = (state_q == S_TW_RX) || (state_q == S_DATA_RX);
  assign busy     = (state_q != S_DATA_RX);
  assign accept   = in_valid && in_ready;

  assign cnt_inc       = cnt_q + CW'(1);
  assign stg_inc       = stg_q + SW'(1);
  // Last address of the current stage: stage s holds RADIX/2 >> s entries.
  assign tw_last       = (CW'(HALF) >> stg_q) - CW'(1);
  assign cnt_last_half = (cnt_q == CW'(HALF - 1));
  assign cnt_last_full = (cnt_q == CW'(RADIX - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stg_d        = stg_q;
    byte_d       = byte_q;
    ram_we_d     = '0;
    ram_addr_d   = '0;
    ram_wdata_d  = '0;
    ntt_start_d  = 1'b0;
    ntt_data_d   = ntt_data_q;
    tx_start_d   = 1'b0;
    tx_byte_d    = tx_byte_q;
    frame_done_d = 1'b0;
    tw_we        = 1'b0;
    tw_waddr     = cnt_q[ADDR_WIDTH-1:0];
    d_we         = 1'b0;
    d_waddr      = cnt_q[IW-1:0];
    d_wdata      = in_data;
    wr_go        = 1'b0;
    wr_stg       = '0;
    wr_j         = '0;
    tw_idx       = '0;
    sel_word     = d_buf_q[cnt_q[IW-1:0]];

    case (state_q)
      S_TW_RX: begin
        if (accept) begin
          tw_we = 1'b1;
          if (cnt_last_half) begin
            // Launch stage 0 / address 0 on the transition so the RAM
            // writes line up exactly with the TW_LOAD cycles.
            state_d = S_TW_LOAD;
            cnt_d   = '0;
            stg_d   = '0;
            wr_go   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_TW_LOAD: begin
        // The registered outputs hold write (stg_q, cnt_q); pick the next.
        if (cnt_q == tw_last) begin
          cnt_d = '0;
          if (stg_q == SW'(NUM_STAGES - 1)) begin
            state_d = S_DATA_RX;
            stg_d   = '0;
          end else begin
            stg_d  = stg_inc;
            wr_go  = 1'b1;
            wr_stg = stg_inc;
          end
        end else begin
          cnt_d  = cnt_inc;
          wr_go  = 1'b1;
          wr_stg = stg_q;
          wr_j   = cnt_inc[ADDR_WIDTH-1:0];
        end
      end

      S_DATA_RX: begin
        if (tw_reload && (cnt_q == '0)) begin
          // Reload wins over a coincident accept; that word is twiddle 0.
          state_d = S_TW_RX;
          cnt_d   = '0;
          if (accept) begin
            tw_we = 1'b1;
            cnt_d = CW'(1);
          end
        end else if (accept) begin
          d_we = 1'b1;
          if (cnt_last_full) begin
            state_d     = S_FEED;
            cnt_d       = '0;
            ntt_start_d = 1'b1;
            ntt_data_d  = d_buf_q[0];
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_FEED: begin
        // Outputs currently show sample cnt_q; stage the next one.
        if (cnt_last_full) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
        end else begin
          cnt_d       = cnt_inc;
          ntt_start_d = 1'b1;
          ntt_data_d  = d_buf_q[cnt_inc[IW-1:0]];
        end
      end

      S_COLLECT: begin
        if (res_valid) begin
          d_we    = 1'b1;
          d_wdata = res_data;
          if (cnt_last_full) begin
            state_d = S_SEND_PREP;
            cnt_d   = '0;
            byte_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_SEND_PREP: begin
        tx_start_d = 1'b1;
        for (int k = 0; k < BPW; k++) begin
          if (byte_q == BCW'(k)) tx_byte_d = sel_word[k*8 +: 8];
        end
        state_d = S_SEND_WAIT;
      end

      S_SEND_WAIT: begin
        if (tx_done) begin
          state_d = S_SEND_PREP;
          if (byte_q == BCW'(BPW - 1)) begin
            byte_d = '0;
            if (cnt_last_full) begin
              state_d      = S_DATA_RX;
              cnt_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            byte_d = byte_q + BCW'(1);
          end
        end
      end

      default: state_d = S_TW_RX;
    endcase

    if (wr_go) begin
      tw_idx                                         = wr_j << wr_stg;
      ram_we_d[wr_stg]                               = 1'b1;
      ram_addr_d[wr_stg*ADDR_WIDTH +: ADDR_WIDTH]    = wr_j;
      ram_wdata_d[wr_stg*W +: W]                     = tw_buf_q[tw_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_TW_RX;
      cnt_q        <= '0;
      stg_q        <= '0;
      byte_q       <= '0;
      ram_we_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ntt_start_q  <= 1'b0;
      ntt_data_q   <= '0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stg_q        <= stg_d;
      byte_q       <= byte_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ntt_start_q  <= ntt_start_d;
      ntt_data_q   <= ntt_data_d;
      tx_start_q   <= tx_start_d;
      tx_byte_q    <= tx_byte_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffers are plain storage: never reset, survive aborts.
  always_ff @(posedge clk) begin
    if (tw_we) tw_buf_q[tw_waddr] <= in_data;
    if (d_we)  d_buf_q[d_waddr]   <= d_wdata;
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ntt_start  = ntt_start_q;
  assign ntt_data   = ntt_data_q;
  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/ntt_frame_sequencer.md
Name: ntt_frame_sequencer

Overview:
- Frame-level controller for the NTT core. It sits between the UART word assembler and the UART byte transmitter.
- It takes one inbound word stream and sequences three jobs:
  - twiddle capture, with decimated preload into the per-stage twiddle RAMs;
  - input-frame capture, then back-to-back feed to the NTT;
  - result capture, then little-endian byte serialisation to the transmitter.
- Twiddles persist across frames. Reload happens only on request.

Parameters:
- W, 32, data/twiddle word width (multiple of 8)
- RADIX, 16, NTT points per frame (power of 2, >=4)
- NUM_STAGES, $clog2(RADIX), number of butterfly stages / twiddle RAMs
- ADDR_WIDTH, $clog2(RADIX/2), twiddle RAM address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  inbound word valid
- in_data  in  W  inbound word
- in_ready  out  1  sequencer accepts in_data this cycle
- tw_reload  in  1  pulse: return to twiddle capture (honoured only in DATA_RX with 0 words accepted)
- ram_we  out  NUM_STAGES  per-stage twiddle RAM write enable
- ram_addr  out  NUM_STAGES*ADDR_WIDTH  per-stage write address, stage s at slice [s*ADDR_WIDTH +: ADDR_WIDTH]
- ram_wdata  out  NUM_STAGES*W  per-stage write data, stage s at slice [s*W +: W]
- ntt_start  out  1  high during all RADIX feed cycles
- ntt_data  out  W  input sample to NTT
- res_valid  in  1  NTT result valid
- res_data  in  W  NTT result word
- tx_start  out  1  one-cycle pulse launching tx_byte
- tx_byte  out  8  byte to transmitter
- tx_done  in  1  transmitter finished current byte
- busy  out  1  state != DATA_RX
- frame_done  out  1  one-cycle pulse after last byte's tx_done

Behaviour:
- Reset: state=TW_RX, all counters 0, and every output 0 except busy=1 (ram_we, ram_addr, ram_wdata, ntt_start, ntt_data, tx_start, tx_byte, frame_done). Reset mid-operation aborts everything. RAM contents and buffers are not cleared.
- All outputs are registered except in_ready and busy, which are decoded combinationally from state.
- Accept = in_valid && in_ready.
- TW_RX:
  - in_ready=1. Accepted word k is stored at tw_buf[k].
  - After RADIX/2 accepts -> TW_LOAD.
- TW_LOAD:
  - in_ready=0. One RAM write per cycle.
  - Loops stage s=0..NUM_STAGES-1 and j=0..(RADIX/2>>s)-1.
  - Each write drives ram_we[s]=1, addr slice s=j, wdata slice s=tw_buf[j<<s]. Only one ram_we bit is high at a time.
  - Total RADIX-1 writes, no gaps. The cycle after the last write: ram_we=0, state -> DATA_RX.
- DATA_RX:
  - in_ready=1. Accepted word k is stored at d_buf[k].
  - After RADIX accepts -> FEED.
  - tw_reload with count==0 -> TW_RX and resets tw index. tw_reload is ignored elsewhere.
  - If tw_reload and an accept occur in the same cycle at count==0, tw_reload wins and the word is stored as tw_buf[0].
- FEED:
  - For RADIX consecutive cycles: ntt_start=1, ntt_data=d_buf[i] for i=0..RADIX-1.
  - Next cycle: ntt_start=0 -> COLLECT.
- COLLECT:
  - Each res_valid stores res_data at d_buf[r], r++. The data buffer is reused.
  - After RADIX results -> SEND.
  - res_valid is ignored in all other states. This includes res_valid arriving during the FEED cycles.
- SEND:
  - Sub-states PREP and WAIT.
  - PREP: tx_byte = d_buf[w][8b+7:8b], tx_start pulse 1 cycle -> WAIT.
  - WAIT: on tx_done advance b. Once b reaches W/8, set b=0 and w++. Then -> PREP.
  - Byte order: word 0 first, LSB byte first. Total RADIX*W/8 bytes.
  - After the last tx_done: frame_done=1 for 1 cycle, state -> DATA_RX (twiddles retained).
  - tx_done outside WAIT is ignored.
- Counters are sized to hold their terminal count (RADIX and RADIX/2) without wrap. Index wrap never occurs because terminal counts force state exit.
- Latency to the first tx_start is 2 cycles after the last res_valid.

Test Plan:
- Twiddle load, RADIX=16, send twiddles 100..107:
  - exactly 15 writes;
  - stage0 addr0..7 data 100..107;
  - stage1 addr0..3 data 100,102,104,106;
  - stage2 data 100,104;
  - stage3 addr0 data 100;
  - then DATA_RX with busy=0.
- Feed: send 16 words 0x10..0x1F -> ntt_start high exactly 16 cycles, with ntt_data=0x10..0x1F in order; in_ready=0 throughout.
- Collect and send:
  - Stimulus: return res 0xA0B0C0D0, then 0x1..0xF, with random res_valid gaps; respond to tx_start with tx_done after random 1..20 cycles.
  - Response: 64 bytes starting D0,C0,B0,A0,01,00,00,00; then frame_done pulses once.
- Second frame without reload: send 16 new words -> no ram_we activity; feed proceeds immediately.
- tw_reload in DATA_RX at count 0 -> in_ready stays 1; the next 8 words rewrite all stages. The same pulse after 1 data word is ignored.
- Reset asserted mid-SEND (word 5) -> next cycle tx_start=0, busy=1, state TW_RX. A full reload plus frame then completes correctly.
